asrv32_uart_loader: RTL and testbench
=====================================

Name: asrv32_uart_loader

Overview:
- Hardware boot loader that fills SoC memory over a UART serial line and holds the core in reset until a valid image has been written.
- Sits beside asrv32_soc's memory: it drives the data-memory write port (enable, address, data, mask) and the core reset.
- The image is what the bench otherwise preloads; after load the core runs and the bench checks results as usual.
- Receives 8N1 bytes, decodes a framed packet, assembles little-endian words and writes one word per write strobe.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range >= 4.
- MEMORY_DEPTH, 8192, memory size in bytes, used for the bounds check.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- i_rx  input  1  UART receive line, asynchronous, idle high
- o_wr_en  output  1  one-cycle memory write strobe
- o_wr_addr  output  32  byte address of the word write, always word-aligned
- o_wr_data  output  32  word to write
- o_wr_mask  output  4  byte mask, always 4'b1111 when o_wr_en is high
- o_core_rst  output  1  active-high core reset request
- o_busy  output  1  packet in progress (any state other than IDLE)
- o_done  output  1  sticky: last packet loaded with a good checksum
- o_err  output  1  sticky: last packet rejected

Behaviour:
- Reset, synchronous, active-high: all outputs 0 except o_core_rst=1. Synchronizer flops are set to 1. FSM goes to IDLE. Any in-flight packet is discarded.
- RX path:
  - i_rx passes through a 2-flop synchronizer.
  - A falling edge starts bit timing. The start bit is re-checked at CLKS_PER_BIT/2; if high it is a glitch and RX returns to idle.
  - Data bits are sampled at mid-bit, LSB first.
  - Stop bit sampled 0 = framing error: byte dropped, o_err=1, o_done=0, packet FSM returns to IDLE.
  - A good byte raises an internal rx_valid for 1 cycle, CLKS_PER_BIT/2 cycles into the stop bit.
- Packet format: 0xA5, ADDR[4 bytes LE], COUNT[2 bytes LE, words], COUNT x DATA[4 bytes LE], CSUM[1 byte].
  - CSUM = sum mod 256 of every byte after 0xA5, up to but excluding CSUM.
- FSM states: IDLE, ADDR, COUNT, DATA, CSUM.
  - IDLE: bytes other than 0xA5 are ignored. 0xA5 -> ADDR, and sets o_core_rst=1, o_done=0, o_err=0, checksum accumulator=0.
  - ADDR: collects 4 bytes, then -> COUNT.
  - COUNT: collects 2 bytes. Bounds check: reject if ADDR[1:0]!=0 or ADDR+4*COUNT > MEMORY_DEPTH. Use 33-bit arithmetic so the sum cannot wrap.
    - Reject -> o_err=1, go to IDLE; trailing bytes are then treated as IDLE input.
    - Pass -> DATA if COUNT!=0, else CSUM.
  - DATA: collects bytes into a word, LSB byte first. On the 4th byte:
    - o_wr_en=1 for exactly 1 cycle, the cycle after that byte's rx_valid, with o_wr_addr = current address.
    - Address then advances by 4 and the word counter decrements.
    - After the last word -> CSUM.
  - CSUM: compares the received byte with the accumulator.
    - Match -> o_done=1, and o_core_rst deasserts the same cycle o_done rises.
    - Mismatch -> o_err=1, o_core_rst stays 1.
    - Either way -> IDLE.
- Words already written before a late error are not rolled back; the core stays in reset.
- A new 0xA5 after o_done reasserts o_core_rst on the cycle after that byte's rx_valid, so the core can be reloaded.
- o_done and o_err are never both 1.
- No timeout: a truncated packet waits indefinitely, and only rst recovers it.

Test Plan:
- Bench uses CLKS_PER_BIT=4. Send A5 00 10 00 00 02 00 EF BE AD DE 73 00 10 00 CD -> exactly two o_wr_en pulses, in order:
  - addr 0x1000, data 0xDEADBEEF, mask 1111;
  - addr 0x1004, data 0x00100073, mask 1111.
  - Then o_done=1, o_core_rst=0, o_err=0.
- Same packet with CSUM=0xCE -> same two writes, then o_err=1, o_done=0, o_core_rst=1.
- Header ADDR=0x00001FFC, COUNT=2 (MEMORY_DEPTH 8192) -> no o_wr_en, o_err=1 after the COUNT bytes. A following valid packet loads normally.
- Header ADDR=0x00001002 -> unaligned reject, o_err=1, no writes.
- 1-cycle low glitch on i_rx, then a byte with stop bit 0 mid-DATA:
  - glitch -> no rx_valid;
  - framing error -> o_err=1, FSM in IDLE.
- Assert rst during DATA after 2 of 4 bytes -> all outputs at reset values, no write. A resent full packet loads correctly.
- COUNT=0 packet A5 00 00 00 00 00 00 00 -> no writes, o_done=1, o_core_rst=0.

Source files
------------

// File: rtl/asrv32_uart_loader.sv
// UART boot loader: receives framed 8N1 packets, writes little-endian words to
// data memory and holds the core in reset until a checksummed image has landed.
module asrv32_uart_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MEMORY_DEPTH = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rx,
  output logic        o_wr_en,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic [3:0]  o_wr_mask,
  output logic        o_core_rst,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [32:0]   DEPTH   = 33'(MEMORY_DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_COUNT, ST_DATA, ST_CSUM} pkt_state_e;

  // ---------------- UART receiver ----------------
  logic            sync1_q, sync2_q, prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_ferr_q, rx_ferr_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!sync2_q && prev_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_M1) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_M1) begin
        rx_cnt_d   = '0;
        rx_shift_d = {sync2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == BIT_M1) begin
        rx_state_d = RX_IDLE;
        rx_valid_d = sync2_q;
        rx_ferr_d  = !sync2_q;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      sync1_q    <= i_rx;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // ---------------- packet decoder ----------------
  pkt_state_e  state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] addr_q, addr_d, word_q, word_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  csum_q, csum_d;
  logic        wr_en_q, wr_en_d, done_q, done_d, err_q, err_d, core_rst_q, core_rst_d;
  logic [31:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [15:0] count_new;
  logic [32:0] end_addr;

  assign count_new = {rx_shift_q, count_q[15:8]};
  // 33-bit end address so a huge COUNT near the top of the map cannot wrap
  assign end_addr  = {1'b0, addr_q} + {15'b0, count_new, 2'b00};

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    addr_d     = addr_q;
    word_d     = word_q;
    count_d    = count_q;
    csum_d     = csum_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = done_q;
    err_d      = err_q;
    core_rst_d = core_rst_q;
    if (rx_ferr_q) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      done_d  = 1'b0;
    end else if (rx_valid_q) begin
      if (state_q != ST_IDLE) csum_d = csum_q + rx_shift_q;
      case (state_q)
        ST_IDLE: if (rx_shift_q == 8'hA5) begin
          state_d    = ST_ADDR;
          bcnt_d     = '0;
          csum_d     = '0;
          core_rst_d = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end
        ST_ADDR: begin
          addr_d = {rx_shift_q, addr_q[31:8]};
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == 2'd3) begin
            state_d = ST_COUNT;
            bcnt_d  = '0;
          end
        end
        ST_COUNT: begin
          count_d = count_new;
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == 2'd1) begin
            bcnt_d = '0;
            if (addr_q[1:0] != 2'b00 || end_addr > DEPTH) begin
              state_d = ST_IDLE;
              err_d   = 1'b1;
            end else begin
              state_d = (count_new != 16'd0) ? ST_DATA : ST_CSUM;
            end
          end
        end
        ST_DATA: begin
          word_d = {rx_shift_q, word_q[31:8]};
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = {rx_shift_q, word_q[31:8]};
            addr_d    = addr_q + 32'd4;
            count_d   = count_q - 16'd1;
            if (count_q == 16'd1) state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          state_d = ST_IDLE;
          if (rx_shift_q == csum_q) begin
            done_d     = 1'b1;
            core_rst_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bcnt_q     <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      count_q    <= '0;
      csum_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      count_q    <= count_d;
      csum_q     <= csum_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      core_rst_q <= core_rst_d;
    end
  end

  assign o_wr_en    = wr_en_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_wr_mask  = {4{wr_en_q}};
  assign o_core_rst = core_rst_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = done_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_asrv32_uart_loader.sv
// Directed and randomized packets driven over the serial line; writes and
// status flags are compared against a byte-level packet model.
module tb_asrv32_uart_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rx;
  logic        o_wr_en;
  logic [31:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic [3:0]  o_wr_mask;
  logic        o_core_rst, o_busy, o_done, o_err;

  asrv32_uart_loader #(.CLKS_PER_BIT(CPB), .MEMORY_DEPTH(8192)) dut (
    .clk(clk), .rst(rst), .i_rx(i_rx),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_wr_mask(o_wr_mask), .o_core_rst(o_core_rst), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  logic [63:0] exp_q[$];   // {addr, data} the model expects written
  logic [67:0] got_q[$];   // {mask, addr, data} seen on the write port
  logic [7:0]  pkt_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic        exp_done;
  logic [31:0] r_addr;
  int          r_n;
  logic [7:0]  junk;

  always @(negedge clk) if (!rst && o_wr_en) got_q.push_back({o_wr_mask, o_wr_addr, o_wr_data});

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    i_rx = stop;
    repeat (CPB) @(negedge clk);
    i_rx = 1'b1;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic send_pkt();
    foreach (pkt_q[i]) send_byte(pkt_q[i], 1'b1);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err);
    check({tag, "_busy"},     68'(o_busy),     68'(0));
    check({tag, "_done"},     68'(o_done),     68'(done));
    check({tag, "_err"},      68'(o_err),      68'(err));
    check({tag, "_core_rst"}, 68'(o_core_rst), 68'(!done));
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, 68'(got_q.size()), 68'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_wr"}, got_q.pop_front(), {4'hF, exp_q.pop_front()});
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wr_en"},    68'(o_wr_en),    68'(0));
    check({tag, "_wr_addr"},  68'(o_wr_addr),  68'(0));
    check({tag, "_wr_data"},  68'(o_wr_data),  68'(0));
    check({tag, "_wr_mask"},  68'(o_wr_mask),  68'(0));
    check({tag, "_core_rst"}, 68'(o_core_rst), 68'(1));
    check({tag, "_busy"},     68'(o_busy),     68'(0));
    check({tag, "_done"},     68'(o_done),     68'(0));
    check({tag, "_err"},      68'(o_err),      68'(0));
  endtask

  // Packet model: header is accepted only if aligned and the image fits in
  // memory; a rejected packet sends no body so stray 0xA5 bytes cannot appear.
  task automatic build_pkt(input logic [31:0] addr, input int n, input bit corrupt);
    int sum;
    logic [31:0] w;
    bit ok;
    pkt_q.delete();
    pkt_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) pkt_q.push_back(8'((addr >> (8 * i)) & 32'hFF));
    pkt_q.push_back(8'(n % 256));
    pkt_q.push_back(8'(n / 256));
    ok = (addr % 4 == 0) && (longint'(addr) + 4 * longint'(n) <= 64'd8192);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        for (int j = 0; j < 4; j++) pkt_q.push_back(8'((w >> (8 * j)) & 32'hFF));
        exp_q.push_back({addr + 32'(4 * i), w});
      end
      sum = 0;
      for (int i = 1; i < pkt_q.size(); i++) sum += int'(pkt_q[i]);
      pkt_q.push_back(8'((sum + (corrupt ? 1 : 0)) % 256));
    end
    exp_done = ok && !corrupt;
  endtask

  initial begin
    rst  = 1'b1;
    i_rx = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Reference two-word image
    pkt_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD,
              8'hDE, 8'h73, 8'h00, 8'h10, 8'h00, 8'hCD};
    exp_q.push_back({32'h1000, 32'hDEADBEEF});
    exp_q.push_back({32'h1004, 32'h00100073});
    send_pkt();
    check_writes("img");
    check_status("img", 1'b1, 1'b0);

    // New 0xA5 after a load puts the core back into reset
    send_byte(8'hA5, 1'b1);
    repeat (6) @(negedge clk);
    check("reload_core_rst", 68'(o_core_rst), 68'(1));
    check("reload_done", 68'(o_done), 68'(0));
    check("reload_busy", 68'(o_busy), 68'(1));
    pkt_q = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD,
              8'hDE, 8'h73, 8'h00, 8'h10, 8'h00, 8'hCE};
    exp_q.push_back({32'h1000, 32'hDEADBEEF});
    exp_q.push_back({32'h1004, 32'h00100073});
    send_pkt();
    check_writes("badsum");
    check_status("badsum", 1'b0, 1'b1);

    // Out-of-bounds header, trailing bytes ignored, then a clean load
    pkt_q = '{8'hA5, 8'hFC, 8'h1F, 8'h00, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt();
    check_writes("oob");
    check_status("oob", 1'b0, 1'b1);
    build_pkt(32'h0000_1FF8, 2, 1'b0);
    send_pkt();
    check_writes("edge");
    check_status("edge", exp_done, !exp_done);

    pkt_q = '{8'hA5, 8'h02, 8'h10, 8'h00, 8'h00, 8'h01, 8'h00};
    send_pkt();
    check_writes("unaligned");
    check_status("unaligned", 1'b0, 1'b1);

    // Glitch mid-word must not shift the byte stream; framing error aborts
    pkt_q = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h02, 8'h00, 8'h44, 8'h33};
    foreach (pkt_q[i]) send_byte(pkt_q[i], 1'b1);
    @(negedge clk) i_rx = 1'b0;
    @(negedge clk) i_rx = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_busy", 68'(o_busy), 68'(1));
    check("glitch_err", 68'(o_err), 68'(0));
    send_byte(8'h22, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h88, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'h66, 1'b0);
    repeat (6) @(negedge clk);
    exp_q.push_back({32'h0200, 32'h11223344});
    check_writes("frame");
    check_status("frame", 1'b0, 1'b1);

    // Reset in the middle of a word
    pkt_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
    foreach (pkt_q[i]) send_byte(pkt_q[i], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    rst = 1'b0;
    check_writes("midrst");
    build_pkt(32'h0000_0100, 1, 1'b0);
    send_pkt();
    check_writes("resend");
    check_status("resend", exp_done, !exp_done);

    pkt_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pkt();
    check_writes("count0");
    check_status("count0", 1'b1, 1'b0);

    // Randomized packets with junk lead-in, occasional misalignment, edge
    // placement and corrupted checksum
    for (int k = 0; k < 10; k++) begin
      repeat ($urandom_range(0, 2)) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h00;
        send_byte(junk, 1'b1);
      end
      r_addr = 32'($urandom_range(0, 2047)) * 4;
      r_n    = $urandom_range(1, 4);
      if ($urandom_range(0, 3) == 0) r_addr = 32'(8192 - 4 * $urandom_range(0, 5));
      if ($urandom_range(0, 4) == 0) r_addr = r_addr + 32'd2;
      build_pkt(r_addr, r_n, $urandom_range(0, 3) == 0);
      send_pkt();
      check_writes($sformatf("rnd%0d", k));
      check_status($sformatf("rnd%0d", k), exp_done, !exp_done);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
